// File: rtl/control_unit_fsm_pkg.sv
// Instruction-phase encodings shared by control_unit_fsm and the control_unit that consumes it.
package control_unit_fsm_pkg;

    typedef enum logic [1:0] {
        STATE_FETCH   = 2'd0,
        STATE_DECODE  = 2'd1,
        STATE_EXECUTE = 2'd2,
        STATE_STORE   = 2'd3
    } state_e;

endpackage

// File: rtl/control_unit_fsm.sv
// Four-phase instruction sequencer: FETCH -> DECODE -> EXECUTE -> STORE, repeating every 4 clocks.
module control_unit_fsm
    import control_unit_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    output logic [1:0] state,
    output logic       is_fetch,
    output logic       is_decode,
    output logic       is_execute,
    output logic       is_store,
    output logic       instr_done
);

    state_e state_q;
    state_e state_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= STATE_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Any unexpected register value recovers to FETCH.
    always_comb begin
        state_d = STATE_FETCH;
        case (state_q)
            STATE_FETCH:   state_d = STATE_DECODE;
            STATE_DECODE:  state_d = STATE_EXECUTE;
            STATE_EXECUTE: state_d = STATE_STORE;
            STATE_STORE:   state_d = STATE_FETCH;
            default:       state_d = STATE_FETCH;
        endcase
    end

    always_comb begin
        is_fetch   = 1'b0;
        is_decode  = 1'b0;
        is_execute = 1'b0;
        is_store   = 1'b0;
        case (state_q)
            STATE_FETCH:   is_fetch   = 1'b1;
            STATE_DECODE:  is_decode  = 1'b1;
            STATE_EXECUTE: is_execute = 1'b1;
            STATE_STORE:   is_store   = 1'b1;
            default:       is_fetch   = 1'b0;
        endcase
    end

    assign state      = state_q;
    assign instr_done = is_store;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Randomized bench for control_unit_fsm against a cycle-count phase model.
module tb_control_unit_fsm;

    logic       clk;
    logic       rst;
    logic [1:0] state;
    logic       is_fetch;
    logic       is_decode;
    logic       is_execute;
    logic       is_store;
    logic       instr_done;

    int n_checks;
    int n_fail;
    int phase;
    int fetch_cnt;

    control_unit_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .is_fetch   (is_fetch),
        .is_decode  (is_decode),
        .is_execute (is_execute),
        .is_store   (is_store),
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: phase is the number of clocks since the last reset edge, modulo 4.
    task automatic step(input logic r);
        rst = r;
        @(posedge clk);
        if (r) phase = 0;
        else   phase = (phase + 1) % 4;
        #1;
        check_val("state",      int'(state),      phase);
        check_val("is_fetch",   int'(is_fetch),   int'(phase == 0));
        check_val("is_decode",  int'(is_decode),  int'(phase == 1));
        check_val("is_execute", int'(is_execute), int'(phase == 2));
        check_val("is_store",   int'(is_store),   int'(phase == 3));
        check_val("instr_done", int'(instr_done), int'(phase == 3));
        check_val("onehot", int'(is_fetch) + int'(is_decode) + int'(is_execute) + int'(is_store), 1);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        phase     = 0;
        fetch_cnt = 0;
        rst       = 1'b1;

        // Reset held for 2 clocks.
        step(1'b1);
        step(1'b1);

        // Release and run 8 clocks: 1,2,3,0,1,2,3,0.
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            check_val("seq8", int'(state), (i + 1) % 4);
        end

        // Reset while in EXECUTE, then resume at DECODE.
        step(1'b0);
        step(1'b0);
        check_val("pre_rst_exec", int'(state), 2);
        step(1'b1);
        check_val("rst_from_exec", int'(state), 0);
        step(1'b0);
        check_val("resume_decode", int'(state), 1);

        // Reset while in STORE: no extra done pulse.
        step(1'b0);
        step(1'b0);
        check_val("pre_rst_store", int'(state), 3);
        step(1'b1);
        check_val("rst_from_store", int'(state), 0);
        check_val("no_extra_done", int'(instr_done), 0);

        // Free run 1000 clocks.
        for (int i = 0; i < 1000; i++) begin
            step(1'b0);
            if (is_fetch) fetch_cnt++;
        end
        check_val("fetch_cnt_in_range", int'(fetch_cnt >= 249 && fetch_cnt <= 251), 1);

        // Random reset pulses.
        for (int i = 0; i < 300; i++) begin
            step(($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0);
        end

        // Hold reset for 5 clocks: no advance.
        step(1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            check_val("rst_hold", int'(state), 0);
        end
        step(1'b0);
        check_val("post_hold", int'(state), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/control_unit_fsm.md
CONTROL_UNIT_FSM -- requirements
Module: control_unit_fsm

Interface
REQ-001 SHALL have no parameters; state width fixed at 2 bits.
REQ-002 clk  input  1  rising-edge clock; all state updates occur on posedge clk.
REQ-003 rst  input  1  reset: synchronous, active-high, sampled on posedge clk.
REQ-004 state  output  2  current instruction phase: 0=FETCH, 1=DECODE, 2=EXECUTE, 3=STORE; registered.
REQ-005 is_fetch  output  1  high iff state==FETCH.
REQ-006 is_decode  output  1  high iff state==DECODE.
REQ-007 is_execute  output  1  high iff state==EXECUTE.
REQ-008 is_store  output  1  high iff state==STORE.
REQ-009 instr_done  output  1  one-cycle pulse, high during the STORE cycle (equals is_store).

Function
REQ-010 SHALL implement a 4-state Moore machine with FETCH=2'd0, DECODE=2'd1, EXECUTE=2'd2, STORE=2'd3.
REQ-011 SHALL transition unconditionally each clock: FETCH->DECODE->EXECUTE->STORE->FETCH.
REQ-012 SHALL hold no other state; there are no stall, hold or skip conditions.
REQ-013 SHALL drive state directly from the state register, with no combinational path from any input to state.
REQ-014 SHALL decode is_* and instr_done combinationally from the state register only.
REQ-015 Exactly one of is_fetch/is_decode/is_execute/is_store SHALL be high in every cycle.
REQ-016 SHALL give a full instruction period of exactly 4 clocks; FETCH recurs every 4th cycle.
REQ-017 SHALL wrap STORE->FETCH, with no idle cycle inserted between instructions.
REQ-018 SHALL treat any out-of-range or corrupted register value as FETCH on the next clock; this is a defensive default, unreachable with the 2-bit encoding.
REQ-019 SHALL cause no change at non-clock times; simulation-only diagnostics SHALL NOT alter state.

Reset
REQ-020 While rst is high at posedge clk: state SHALL become FETCH (2'd0), is_fetch=1, other strobes=0, instr_done=0.
REQ-021 Reset SHALL have priority over the transition logic.
REQ-022 First posedge with rst low after reset: state SHALL go FETCH->DECODE.
REQ-023 Reset asserted mid-sequence (any state) SHALL force FETCH on that same clock edge; the interrupted instruction is abandoned.
REQ-024 Before the first reset edge, state is undefined (X in simulation); consumers SHALL require an initial reset.

Structure
REQ-025 State encodings (STATE_FETCH/DECODE/EXECUTE/STORE) SHALL live in a shared package or include file, used by control_unit_fsm and the consuming control_unit.
REQ-026 SHALL be a single flat module with no sub-modules: one sequential block for the state register and one combinational block each for next-state and the strobe outputs.
REQ-027 SHALL be synthesizable, with no latches and a fully specified case default for next-state.

Verification
REQ-028 rst=1 for 2 clocks -> state=0, is_fetch=1, instr_done=0 after each edge.
REQ-029 Release rst, run 8 clocks -> state sequence 1,2,3,0,1,2,3,0; instr_done high only on the cycles where state=3.
REQ-030 Assert rst for one clock while state=2 -> state=0 after that edge, then 1 on the next edge.
REQ-031 Assert rst while state=3 -> state=0 after that edge, with no extra instr_done pulse.
REQ-032 Free-run 1000 clocks -> one-hot check on is_* holds every cycle; FETCH count = 250 ±1.
REQ-033 Hold rst=1 for 5 clocks -> state remains 0 throughout, with no advance.
